ula_multiciclo: RTL and testbench

- Execution stage directly downstream of the 16x8 register bank.
- Consumes the two read operands (saida1/saida2) plus an opcode and destination index from control.
- Produces the write-back triple (data, destination register, write strobe) that feeds the register bank's dado/registradorEscrita/write inputs.
- Logic/add ops complete in 1 cycle; MUL/DIV are iterative over WIDTH cycles with a start/busy/done handshake.

---
 rtl/ula_multiciclo.sv | 217 +++++++++++++++++++++
 tb/tb_ula_multiciclo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_multiciclo
//
// Multi-cycle ALU execution stage. It sits directly after the register bank
// and drives that bank's write-back port.
//   - Logic and add-class ops (ADD, SUB, AND, OR, XOR, SLT) finish in 1 cycle.
//   - MUL (shift-add) and DIV (restoring) are iterative and take WIDTH steps.
//   - Handshake: start is sampled in IDLE only. busy is high in ITER and DONE.
//     done and write_en are single-cycle pulses in DONE.
//
// Parameters
//   WIDTH     operand/result width; also the MUL/DIV step count
//   REG_ADDR  destination register index width
//
// Ports
//   clk       system clock; all state changes happen on posedge
//   clr       synchronous active-high reset
//   start     launch an operation (sampled in IDLE only)
//   op        000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//             101 SLT (unsigned), 110 MUL, 111 DIV (unsigned)
//   a, b      operands (register bank saida1 / saida2)
//   rd        destination register index
//   result    write-back data (holds until the next completion)
//   reg_dest  write-back register index (holds until the next completion)
//   write_en  one-cycle write strobe; suppressed on divide-by-zero
//   busy      high whenever the FSM is not in IDLE
//   done      one-cycle completion pulse
//   zero      result == 0; valid with done
//   div_zero  DIV with b == 0; valid with done
//   resto     DIV remainder (only when ULA_RESTO_EN is defined)
//
// Build option
//   ULA_RESTO_EN  adds the resto output and its holding register
// ---------------------------------------------------------------------------
module ula_multiciclo #(
    parameter int WIDTH    = 8,
    parameter int REG_ADDR = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [REG_ADDR-1:0] rd,
    output logic [WIDTH-1:0]    result,
    output logic [REG_ADDR-1:0] reg_dest,
    output logic                write_en,
    output logic                busy,
    output logic                done,
    output logic                zero,
`ifdef ULA_RESTO_EN
    output logic                div_zero,
    output logic [WIDTH-1:0]    resto
`else
    output logic                div_zero
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t state, state_nx;

    logic [CNT_W-1:0]    cnt;
    // MUL: opa = multiplicand (shifts left), opb = multiplier (shifts right),
    //      acc = partial product.
    // DIV: opa = dividend shifting out / quotient shifting in, opb = divisor,
    //      acc = partial remainder.
    logic [WIDTH-1:0]    opa, opb, acc;
    logic                is_div;
    logic [REG_ADDR-1:0] rd_q;

    logic                is_iter_op;
    logic [WIDTH-1:0]    quick_res;
    logic [WIDTH:0]      rem_sh;
    logic [WIDTH-1:0]    step_acc, step_a, step_b;
    logic [WIDTH-1:0]    iter_res;

    assign is_iter_op = (op[2:1] == 2'b11);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = is_iter_op ? S_ITER : S_DONE;
            S_ITER: if (cnt == CNT_LAST) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    // A divide-by-zero completes (done) but must not touch the register bank.
    assign write_en = done && !div_zero;

    // ------------------------------------------------------------------
    // Single-cycle operations
    // ------------------------------------------------------------------
    always_comb begin
        quick_res = '0;
        case (op)
            3'b000: quick_res = a + b;
            3'b001: quick_res = a - b;
            3'b010: quick_res = a & b;
            3'b011: quick_res = a | b;
            3'b100: quick_res = a ^ b;
            3'b101: quick_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: quick_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One MUL / DIV iteration step
    // ------------------------------------------------------------------
    // The partial remainder is always below the divisor, so shifting in one
    // dividend bit needs only one extra bit of headroom for the compare.
    assign rem_sh = {acc, opa[WIDTH-1]};

    always_comb begin
        step_acc = acc;
        step_a   = opa;
        step_b   = opb;
        if (is_div) begin
            if (rem_sh >= {1'b0, opb}) begin
                step_acc = WIDTH'(rem_sh - {1'b0, opb});
                step_a   = {opa[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = rem_sh[WIDTH-1:0];
                step_a   = {opa[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = acc + (opb[0] ? opa : '0);
            step_a   = opa << 1;
            step_b   = opb >> 1;
        end
    end

    // The divisor never changes during DIV, so opb == 0 flags divide-by-zero.
    assign iter_res = is_div ? ((opb == '0) ? '1 : step_a) : step_acc;

    // ------------------------------------------------------------------
    // State, datapath and write-back registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (clr) begin
            state    <= S_IDLE;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            is_div   <= 1'b0;
            rd_q     <= '0;
            result   <= '0;
            reg_dest <= '0;
            zero     <= 1'b0;
            div_zero <= 1'b0;
`ifdef ULA_RESTO_EN
            resto    <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        acc    <= '0;
                        opa    <= a;
                        opb    <= b;
                        is_div <= op[0];
                        rd_q   <= rd;
                        if (!is_iter_op) begin
                            result   <= quick_res;
                            reg_dest <= rd;
                            zero     <= (quick_res == '0);
                            div_zero <= 1'b0;
                        end
                    end
                end
                S_ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= step_acc;
                    opa <= step_a;
                    opb <= step_b;
                    // The last step is folded into the write-back load so the
                    // result is ready in the same cycle done rises.
                    if (cnt == CNT_LAST) begin
                        result   <= iter_res;
                        reg_dest <= rd_q;
                        zero     <= (iter_res == '0);
                        div_zero <= is_div && (opb == '0);
`ifdef ULA_RESTO_EN
                        // With a zero divisor the restoring steps shift the
                        // whole dividend into the remainder, so it equals a.
                        if (is_div) resto <= step_acc;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_ula_multiciclo
//
// Directed bench for ula_multiciclo. The stimulus process pushes the expected
// write-back (and its expected done cycle) into a scoreboard queue. A monitor
// running on the falling edge pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_ula_multiciclo;

    localparam int W = 8;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [R-1:0] rd;
    logic [W-1:0] result;
    logic [R-1:0] reg_dest;
    logic         write_en, busy, done, zero, div_zero;
`ifdef ULA_RESTO_EN
    logic [W-1:0] resto;
`endif

    ula_multiciclo #(.WIDTH(W), .REG_ADDR(R)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .rd       (rd),
        .result   (result),
        .reg_dest (reg_dest),
        .write_en (write_en),
        .busy     (busy),
        .done     (done),
        .zero     (zero),
`ifdef ULA_RESTO_EN
        .div_zero (div_zero),
        .resto    (resto)
`else
        .div_zero (div_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [R-1:0] rd;
        logic         we;
        logic         z;
        logic         dz;
        logic [W-1:0] rem;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Drive one start pulse; optionally record the expected write-back.
    // Called just after a falling edge; returns one falling edge later.
    task automatic launch(input bit push, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [R-1:0] d,
                          input logic [W-1:0] er, input logic [W-1:0] erem);
        exp_t e;
        int   lat;
        lat   = (o[2:1] == 2'b11) ? W + 1 : 1;
        op    = o;
        a     = x;
        b     = y;
        rd    = d;
        start = 1'b1;
        if (push) begin
            e.res = er;
            e.rd  = d;
            e.dz  = (o == 3'b111) && (y == '0);
            e.we  = !e.dz;
            e.z   = (er == '0);
            e.rem = erem;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        // Scramble inputs: the operation in flight must use latched copies.
        start = 1'b0;
        op    = 3'b100;
        a     = 8'h5A;
        b     = 8'hA5;
        rd    = 4'hF;
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [R-1:0] d, input logic [W-1:0] er, input logic [W-1:0] erem);
        launch(1'b1, o, x, y, d, er, erem);
        repeat ((o[2:1] == 2'b11) ? W + 1 : 1) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!clr) begin
            if (write_en && !done) begin
                n_vec++;
                n_err++;
                $display("FAIL we_without_done: got write_en=1 done=0, want write_en=0 (cycle %0d)", cyc);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 result=%0h, want no completion (cycle %0d)",
                             result, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", cyc,      e.cyc);
                    check("result",     result,   e.res);
                    check("reg_dest",   reg_dest, e.rd);
                    check("write_en",   write_en, e.we);
                    check("zero",       zero,     e.z);
                    check("div_zero",   div_zero, e.dz);
`ifdef ULA_RESTO_EN
                    if (e.dz || (e.rem != 8'hXX && e.rd != 4'hX)) check("resto", resto, e.rem);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want $finish");
        $fatal(1);
    end

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        rd    = '0;
        repeat (2) @(negedge clk);
        check("rst_result",   result,   8'h00);
        check("rst_reg_dest", reg_dest, 4'h0);
        check("rst_write_en", write_en, 1'b0);
        check("rst_busy",     busy,     1'b0);
        check("rst_done",     done,     1'b0);
        check("rst_zero",     zero,     1'b0);
        check("rst_div_zero", div_zero, 1'b0);
`ifdef ULA_RESTO_EN
        check("rst_resto",    resto,    8'h00);
`endif
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // ADD, then confirm the pulses drop and the write-back data holds.
        run(3'b000, 8'hF0, 8'h20, 4'd3, 8'h10, 8'h00);
        check("hold_done",     done,     1'b0);
        check("hold_write_en", write_en, 1'b0);
        check("hold_result",   result,   8'h10);
        check("hold_reg_dest", reg_dest, 4'd3);

        // MUL with a start pulse during ITER that must be ignored.
        launch(1'b1, 3'b110, 8'd13, 8'd11, 4'd5, 8'h8F, 8'h00);
        repeat (2) @(negedge clk);
        check("mul_busy", busy, 1'b1);
        op    = 3'b000;
        a     = 8'd1;
        b     = 8'd1;
        rd    = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);

        // DIV, including divide-by-zero.
        run(3'b111, 8'd200, 8'd7,  4'd6, 8'd28,  8'd4);
        run(3'b111, 8'd9,   8'd0,  4'd7, 8'hFF,  8'd9);
        run(3'b111, 8'd255, 8'd1,  4'd8, 8'd255, 8'd0);
        run(3'b111, 8'd5,   8'd10, 4'd9, 8'd0,   8'd5);

        // Back-to-back single-cycle ops, every 2 cycles.
        run(3'b001, 8'd5,   8'd5,   4'd1,  8'h00, 8'h00);
        run(3'b101, 8'd3,   8'd9,   4'd2,  8'h01, 8'h00);
        run(3'b101, 8'd9,   8'd3,   4'd2,  8'h00, 8'h00);
        run(3'b001, 8'd3,   8'd5,   4'd4,  8'hFE, 8'h00);
        run(3'b010, 8'hCC,  8'hAA,  4'd10, 8'h88, 8'h00);
        run(3'b011, 8'hCC,  8'hAA,  4'd11, 8'hEE, 8'h00);
        run(3'b100, 8'hCC,  8'hAA,  4'd12, 8'h66, 8'h00);
        run(3'b000, 8'hFF,  8'h01,  4'd13, 8'h00, 8'h00);
        run(3'b110, 8'hFF,  8'hFF,  4'd14, 8'h01, 8'h00);

        // MUL aborted by clr in the fourth ITER cycle: no completion expected.
        launch(1'b0, 3'b110, 8'd13, 8'd11, 4'd5, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_busy",     busy,     1'b0);
        check("abort_done",     done,     1'b0);
        check("abort_write_en", write_en, 1'b0);
        check("abort_result",   result,   8'h00);
        repeat (10) @(negedge clk);

        run(3'b000, 8'd1, 8'd2, 4'd6, 8'd3, 8'h00);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
